// File: rtl/reg_file_write_arbiter.sv
// reg_file_write_arbiter
// Shares the direct-access master port of a register file between
// NUM_REQUESTERS requesters. A request is accepted in IDLE by a round-robin
// search, runs against the register file in EXEC, and is answered with a
// one-cycle pulse in RESP (one transaction per three cycles at most).
//
// Handshake: a request is transferred on the rising edge where req_valid[k]
// and req_ready[k] are both high. req_ready is only ever raised in IDLE, for
// at most one requester, and valid may be withdrawn at any time before that
// edge without side effects. rsp_valid[k] is a single-cycle pulse with no
// back-pressure; rsp_rdata/rsp_err are meaningful only while it is high.
//
// Optional build macro: RF_ARB_BYTE_STROBE_EN adds req_wstrb and turns writes
// into byte-masked read-modify-write (REGISTER_WIDTH must be a multiple of 8).
module reg_file_write_arbiter #(
   parameter int REGISTER_WIDTH = 32,
   parameter int NUM_REGISTERS  = 16,
   parameter int NUM_REQUESTERS = 4,
   parameter int ADDR_WIDTH     = 8
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [NUM_REQUESTERS-1:0]                req_valid,
   output logic [NUM_REQUESTERS-1:0]                req_ready,
   input  logic [NUM_REQUESTERS-1:0]                req_we,
   input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQUESTERS*REGISTER_WIDTH-1:0] req_wdata,
`ifdef RF_ARB_BYTE_STROBE_EN
   input  logic [NUM_REQUESTERS*(REGISTER_WIDTH/8)-1:0] req_wstrb,
`endif
   output logic [NUM_REQUESTERS-1:0]                rsp_valid,
   output logic [REGISTER_WIDTH-1:0]                rsp_rdata,
   output logic                                     rsp_err,
   output logic [NUM_REGISTERS-1:0]                 rf_write_req,
   output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]  rf_write_data,
   input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]  rf_read_data,
   output logic [1:0]                               dbg_state
);

   localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGISTERS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                    state, next_state;
   logic [PTR_W-1:0]          rr_ptr;
   logic [PTR_W-1:0]          gnt_idx;
   logic                      gnt_found;
   logic                      cap_we;
   logic [ADDR_WIDTH-1:0]     cap_addr;
   logic [PTR_W-1:0]          cap_g;
   logic                      cap_in_range;
   logic                      win_we;
   logic [ADDR_WIDTH-1:0]     win_addr;
   logic [REGISTER_WIDTH-1:0] win_wdata;
   logic [REGISTER_WIDTH-1:0] win_new;
   logic [ADDR_WIDTH-1:0]     lookup_addr;
   logic [REGISTER_WIDTH-1:0] lookup_old;

   assign dbg_state    = state;
   assign cap_in_range = {1'b0, cap_addr} < REG_LIMIT;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      cand      = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
         cand = idx[PTR_W-1:0];
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Winner's request fields and one register lookup shared by the RMW merge
   // (while accepting in IDLE) and the read sample (in EXEC).
   always_comb begin
      win_we      = req_we[gnt_idx];
      win_addr    = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      win_wdata   = req_wdata[int'(gnt_idx)*REGISTER_WIDTH +: REGISTER_WIDTH];
      lookup_addr = (state == IDLE) ? win_addr : cap_addr;
      lookup_old  = '0;
      for (int i = 0; i < NUM_REGISTERS; i++) begin
         if (lookup_addr == ADDR_WIDTH'(i))
            lookup_old = rf_read_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
      end
   end

`ifdef RF_ARB_BYTE_STROBE_EN
   localparam int NB = REGISTER_WIDTH / 8;
   logic [NB-1:0]             win_wstrb;
   logic [REGISTER_WIDTH-1:0] win_mask;

   // Byte-masked merge of the new data over the register's current value.
   always_comb begin
      win_wstrb = req_wstrb[int'(gnt_idx)*NB +: NB];
      win_mask  = '0;
      for (int b = 0; b < NB; b++) win_mask[b*8 +: 8] = {8{win_wstrb[b]}};
      win_new = (lookup_old & ~win_mask) | (win_wdata & win_mask);
   end
`else
   // Full-register replace.
   always_comb begin
      win_new = win_wdata;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next state and grant; ready is held low while reset is asserted.
   always_comb begin
      next_state = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (rst_n && gnt_found) begin
               req_ready[gnt_idx] = 1'b1;
               next_state         = EXEC;
            end
         end
         EXEC:    next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture on accept, drive the register file during EXEC, answer in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr        <= '0;
         cap_we        <= 1'b0;
         cap_addr      <= '0;
         cap_g         <= '0;
         rf_write_req  <= '0;
         rf_write_data <= '0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  cap_we   <= win_we;
                  cap_addr <= win_addr;
                  cap_g    <= gnt_idx;
                  // Out-of-range addresses match no register, so no strobe.
                  for (int i = 0; i < NUM_REGISTERS; i++) begin
                     if (win_we && win_addr == ADDR_WIDTH'(i)) begin
                        rf_write_req[i] <= 1'b1;
                        rf_write_data[i*REGISTER_WIDTH +: REGISTER_WIDTH] <= win_new;
                     end
                  end
               end
            end
            EXEC: begin
               rf_write_req     <= '0;
               rf_write_data    <= '0;
               rsp_valid[cap_g] <= 1'b1;
               rsp_rdata        <= (cap_in_range && !cap_we) ? lookup_old : '0;
               rsp_err          <= !cap_in_range;
            end
            RESP: begin
               rsp_valid <= '0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               rr_ptr    <= (int'(cap_g) == NUM_REQUESTERS-1) ? '0 : cap_g + PTR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Testbench for reg_file_write_arbiter (default parameters: 32-bit registers,
// 16 registers, 4 requesters, 8-bit addresses). Includes a behavioural
// register file on the rf_* side and a response scoreboard.
module tb_reg_file_write_arbiter;
   localparam int W  = 32;
   localparam int NR = 16;
   localparam int NQ = 4;
   localparam int AW = 8;

   logic              clk;
   logic              rst_n;
   logic [NQ-1:0]     req_valid;
   logic [NQ-1:0]     req_ready;
   logic [NQ-1:0]     req_we;
   logic [NQ*AW-1:0]  req_addr;
   logic [NQ*W-1:0]   req_wdata;
`ifdef RF_ARB_BYTE_STROBE_EN
   logic [NQ*4-1:0]   req_wstrb;
`endif
   logic [NQ-1:0]     rsp_valid;
   logic [W-1:0]      rsp_rdata;
   logic              rsp_err;
   logic [NR-1:0]     rf_write_req;
   logic [NR*W-1:0]   rf_write_data;
   logic [NR*W-1:0]   rf_read_data;
   logic [1:0]        dbg_state;

   int                errors = 0;
   int                checks = 0;
   logic [36:0]       exp_q[$];
   logic [W-1:0]      ref_reg [NR];
   bit   [NR-1:0]     written = '0;
   logic [NQ-1:0]     last_ready;
   logic [3:0]        strobe_val = 4'hF;

   logic [W-1:0]      rf_mem [NR];
   int                wr_cnt [NR];

   reg_file_write_arbiter #(
      .REGISTER_WIDTH(W), .NUM_REGISTERS(NR), .NUM_REQUESTERS(NQ), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RF_ARB_BYTE_STROBE_EN
      .req_wstrb(req_wstrb),
`endif
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rf_write_req(rf_write_req), .rf_write_data(rf_write_data),
      .rf_read_data(rf_read_data), .dbg_state(dbg_state)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural register file: writes land on the clock edge.
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) begin
         if (rf_write_req[i]) begin
            rf_mem[i] <= rf_write_data[i*W +: W];
            wr_cnt[i] <= wr_cnt[i] + 1;
         end
      end
   end

   always_comb begin
      rf_read_data = '0;
      for (int i = 0; i < NR; i++) rf_read_data[i*W +: W] = rf_mem[i];
   end

   // Scoreboard: every response pulse is compared with the oldest expectation.
   always @(negedge clk) begin
      logic [36:0] e;
      if (rst_n && rsp_valid !== '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid=%b err=%b rdata=%h, no response expected",
                     rsp_valid, rsp_err, rsp_rdata);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_valid, rsp_err, rsp_rdata} !== e) begin
               errors++;
               $display("FAIL rsp_compare: got valid=%b err=%b rdata=%h, expected valid=%b err=%b rdata=%h",
                        rsp_valid, rsp_err, rsp_rdata, e[36:33], e[32], e[31:0]);
            end
         end
      end
   end

   // Driver: present one request at posedge+1, hold until granted (bounded),
   // return 1ns after the accepting edge. Pushes the expected response.
   task automatic issue(input int k, input logic we, input logic [AW-1:0] addr,
                        input logic [W-1:0] wdata, input bit push);
      logic [W-1:0] mask;
      logic [W-1:0] rd;
      logic         err;
      bit           got;
      err  = (addr >= AW'(NR));
      mask = '1;
`ifdef RF_ARB_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{strobe_val[b]}};
      req_wstrb[k*4 +: 4] = strobe_val;
`endif
      rd = '0;
      if (!err && !we) rd = ref_reg[addr[3:0]];
      if (push) exp_q.push_back({4'b0001 << k, err, rd});
      if (push && !err && we) begin
         ref_reg[addr[3:0]] = (ref_reg[addr[3:0]] & ~mask) | (wdata & mask);
         written[addr[3:0]] = 1'b1;
      end
      req_valid[k]          = 1'b1;
      req_we[k]             = we;
      req_addr[k*AW +: AW]  = addr;
      req_wdata[k*W +: W]   = wdata;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (req_ready[k]) begin
            got        = 1'b1;
            last_ready = req_ready;
         end
         @(posedge clk);
         #1;
      end
      req_valid[k] = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL grant_timeout: requester %0d not granted, req_ready=%b", k, req_ready);
      end
   endtask

   // Wait (bounded) until every expected response has been seen.
   task automatic wait_drain();
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'b0001;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
`ifdef RF_ARB_BYTE_STROBE_EN
      req_wstrb = '1;
`endif
      @(negedge clk);
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b required 0", req_ready); end
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
      checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", rsp_err); end
      checks++; if (rf_write_req !== '0) begin errors++; $display("FAIL reset_wr_req: got %h required 0", rf_write_req); end
      checks++; if (rf_write_data !== '0) begin errors++; $display("FAIL reset_wr_data: nonzero, required 0"); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_write();
      issue(0, 1'b1, 8'd3, 32'hDEADBEEF, 1'b1);
      checks++; if (last_ready !== 4'b0001) begin errors++; $display("FAIL sw_ready: got %b required 0001", last_ready); end
      @(negedge clk);
      checks++; if (rf_write_req !== 16'h0008) begin errors++; $display("FAIL sw_wr_req: got %h required 0008", rf_write_req); end
      checks++; if (rf_write_data[3*W +: W] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wr_data: got %h required deadbeef", rf_write_data[3*W +: W]); end
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL sw_early_rsp: got %b required 0", rsp_valid); end
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin errors++; $display("FAIL sw_rsp: got valid=%b err=%b required 0001/0", rsp_valid, rsp_err); end
      checks++; if (rf_write_req !== '0) begin errors++; $display("FAIL sw_wr_req_clear: got %h required 0", rf_write_req); end
      checks++; if (rf_read_data[3*W +: W] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_reg_value: got %h required deadbeef", rf_read_data[3*W +: W]); end
      @(posedge clk);
      #1;
      issue(0, 1'b0, 8'd3, 32'h0, 1'b1);
      wait_drain();
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      int n;
      int cyc;
      int last_cyc;
      do_reset();
`ifdef RF_ARB_BYTE_STROBE_EN
      req_wstrb = '1;
`endif
      for (int i = 0; i < 5; i++) exp_q.push_back({4'b0001 << order[i], 1'b0, 32'h0});
      for (int k = 0; k < NQ; k++) begin
         req_we[k]            = 1'b1;
         req_addr[k*AW +: AW] = 8'd5;
         req_wdata[k*W +: W]  = 32'h5000_0000 | k;
      end
      req_valid = '1;
      n = 0; cyc = 0; last_cyc = 0;
      for (int c = 0; c < 60 && n < 5; c++) begin
         @(negedge clk);
         cyc++;
         if (req_ready !== '0) begin
            checks++;
            if (req_ready !== (4'b0001 << order[n])) begin
               errors++;
               $display("FAIL rr_order: grant %0d got %b required %b", n, req_ready, 4'b0001 << order[n]);
            end
            if (n > 0) begin
               checks++;
               if (cyc - last_cyc != 3) begin
                  errors++;
                  $display("FAIL rr_spacing: grant %0d after %0d cycles required 3", n, cyc - last_cyc);
               end
            end
            if (n == 4) begin
               checks++;
               if (rf_read_data[5*W +: W] !== 32'h5000_0003) begin
                  errors++;
                  $display("FAIL rr_final_value: got %h required 50000003", rf_read_data[5*W +: W]);
               end
            end
            last_cyc = cyc;
            n++;
         end
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      checks++;
      if (n != 5) begin errors++; $display("FAIL rr_grants: got %0d grants required 5", n); end
      ref_reg[5] = 32'h5000_0000;
      written[5] = 1'b1;
      wait_drain();
   endtask

   task automatic test_out_of_range();
      issue(2, 1'b1, 8'd20, 32'h0000_CAFE, 1'b1);
      @(negedge clk);
      checks++; if (rf_write_req !== '0) begin errors++; $display("FAIL oor_wr_req: got %h required 0", rf_write_req); end
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
         errors++;
         $display("FAIL oor_write_rsp: got valid=%b err=%b rdata=%h required 0100/1/0", rsp_valid, rsp_err, rsp_rdata);
      end
      @(posedge clk);
      #1;
      issue(1, 1'b0, 8'd20, 32'h0, 1'b1);
      wait_drain();
   endtask

   task automatic test_reset_mid_exec();
      bit got;
      int wr7;
      do_reset();
      issue(2, 1'b0, 8'd3, 32'h0, 1'b1);
      wait_drain();
      wr7 = wr_cnt[7];
      issue(1, 1'b1, 8'd7, 32'h7777_7777, 1'b0);
      checks++; if (rf_write_req !== 16'h0080) begin errors++; $display("FAIL rst_exec_wr_req: got %h required 0080", rf_write_req); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (rf_write_req !== '0) begin errors++; $display("FAIL rst_async_wr_req: got %h required 0", rf_write_req); end
      checks++; if (rf_write_data !== '0) begin errors++; $display("FAIL rst_async_wr_data: nonzero, required 0"); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_async_state: got %0d required 0", dbg_state); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rst_no_rsp: got %b required 0", rsp_valid); end
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (wr_cnt[7] != wr7) begin errors++; $display("FAIL rst_lost_write: reg7 written %0d times required %0d", wr_cnt[7] - wr7, 0); end
`ifdef RF_ARB_BYTE_STROBE_EN
      req_wstrb = '1;
`endif
      for (int k = 0; k < NQ; k++) begin
         req_we[k]            = 1'b1;
         req_addr[k*AW +: AW] = 8'd9;
         req_wdata[k*W +: W]  = 32'h0000_0090 | k;
      end
      exp_q.push_back({4'b0001, 1'b0, 32'h0});
      req_valid = '1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (req_ready !== '0) begin
            got = 1'b1;
            checks++;
            if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_winner: got %b required 0001", req_ready); end
         end
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      checks++; if (!got) begin errors++; $display("FAIL rst_grant_timeout: no grant after reset, required 1"); end
      ref_reg[9] = 32'h0000_0090;
      written[9] = 1'b1;
      wait_drain();
   endtask

   task automatic test_withdraw();
      issue(0, 1'b0, 8'd9, 32'h0, 1'b1);
      req_valid[1]          = 1'b1;
      req_we[1]             = 1'b1;
      req_addr[1*AW +: AW]  = 8'd2;
      @(negedge clk);
      checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL wd_ready_exec: got %b required 0", req_ready[1]); end
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL wd_req1_served: ready=%b rsp=%b required 0/0", req_ready[1], rsp_valid[1]);
         end
      end
      @(posedge clk);
      #1;
      wait_drain();
   endtask

   task automatic test_random();
      int          k;
      logic [3:0]  a;
      logic        we;
      logic [W-1:0] wd;
      for (int n = 0; n < 10; n++) begin
         k  = $urandom_range(0, NQ-1);
         a  = 4'($urandom_range(0, NR-1));
         we = 1'($urandom_range(0, 1));
         if (!written[a]) we = 1'b1;
         wd = $urandom;
         issue(k, we, {4'h0, a}, wd, 1'b1);
         wait_drain();
      end
   endtask

`ifdef RF_ARB_BYTE_STROBE_EN
   task automatic test_strobe();
      strobe_val = 4'hF;
      issue(0, 1'b1, 8'd4, 32'h1122_3344, 1'b1);
      wait_drain();
      strobe_val = 4'b0101;
      issue(1, 1'b1, 8'd4, 32'hAABB_CCDD, 1'b1);
      wait_drain();
      checks++; if (rf_read_data[4*W +: W] !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_merge: got %h required 11bb33dd", rf_read_data[4*W +: W]); end
      strobe_val = 4'b0000;
      issue(2, 1'b1, 8'd4, 32'hFFFF_FFFF, 1'b1);
      wait_drain();
      checks++; if (rf_read_data[4*W +: W] !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_zero: got %h required 11bb33dd", rf_read_data[4*W +: W]); end
      strobe_val = 4'hF;
      issue(3, 1'b0, 8'd4, 32'h0, 1'b1);
      wait_drain();
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_out_of_range();
      test_reset_mid_exec();
      test_withdraw();
      test_random();
`ifdef RF_ARB_BYTE_STROBE_EN
      test_strobe();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
